// File: rtl/arb_grant_mux.sv
// arb_grant_mux: sits behind a round-robin arbiter. It gates the arbiter's
// requests with local buffer space, validates the returned grant, accepts
// at most one granted beat per cycle into a 2-entry FIFO, and presents the
// FIFO head on a valid/ready port tagged with the source channel index.
module arb_grant_mux #(
    parameter  int N  = 2,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   requests,
    input  logic [N-1:0]   grants,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    input  logic           out_ready,
    output logic [1:0]     count,
    output logic           err_grant
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  mem_data_reg [2];
    logic [SW-1:0] mem_src_reg  [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic          err_reg;
    logic          err_next;

    // ------------------------------------------------------------------
    // Request gating and grant validation
    // ------------------------------------------------------------------
    logic          space;
    logic          grant_any;
    logic          grant_onehot;
    logic          grant_subset;
    logic          legal;
    logic          push;
    logic          pop;
    logic [W-1:0]  push_data;
    logic [SW-1:0] push_src;

    // Space ignores a same-cycle pop so out_ready never reaches requests.
    assign space     = (count_reg < 2'd2);
    assign requests  = in_valid & {N{space}};

    assign grant_any    = |grants;
    // x & (x-1) clears the lowest set bit; zero afterwards means one-hot.
    assign grant_onehot = grant_any && ((grants & (grants - N'(1))) == '0);
    assign grant_subset = ((grants & ~requests) == '0);
    assign legal        = grant_onehot && grant_subset;

    assign in_ready  = grants & {N{legal}};
    assign push      = legal;
    assign pop       = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Granted-channel data/source selection as an AND-OR mux. Only valid
    // when the grant is one-hot, which is exactly when push is asserted.
    // ------------------------------------------------------------------
    logic [W-1:0]  data_masked [N];
    logic [SW-1:0] src_masked  [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign data_masked[gi] = in_data[gi*W +: W] & {W{grants[gi]}};
            assign src_masked[gi]  = grants[gi] ? SW'(gi) : '0;
        end
    endgenerate

    // OR-reduce the per-channel masked terms into the push payload.
    always_comb begin
        push_data = '0;
        push_src  = '0;
        for (int i = 0; i < N; i++) begin
            push_data = push_data | data_masked[i];
            push_src  = push_src  | src_masked[i];
        end
    end

    // ------------------------------------------------------------------
    // Occupancy and error next-state
    // ------------------------------------------------------------------

    // Occupancy moves by push minus pop; both together leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // A nonzero grant that fails validation latches the sticky error.
    always_comb begin
        err_next = err_reg | (grant_any & ~legal);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FIFO pointers, occupancy and error flag; reset discards buffered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // FIFO storage: the accepted beat is written at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_reg[i] <= '0;
                mem_src_reg[i]  <= '0;
            end
        end else if (push) begin
            mem_data_reg[wr_ptr_reg] <= push_data;
            mem_src_reg[wr_ptr_reg]  <= push_src;
        end
    end

    // ------------------------------------------------------------------
    // Output port: head of FIFO straight from storage, no input bypass.
    // ------------------------------------------------------------------
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = mem_data_reg[rd_ptr_reg];
    assign out_src   = mem_src_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign err_grant = err_reg;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux (N=2, W=8) paired with a small
// 2-request round-robin arbiter model. Grants can be overridden to
// inject illegal patterns.
module tb_arb_grant_mux;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic [1:0]  requests;
    logic [1:0]  grants;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [0:0]  out_src;
    logic        out_ready;
    logic [1:0]  count;
    logic        err_grant;

    int compared;
    int mismatched;

    // Arbiter model and grant override
    logic        arb_ptr;
    logic [1:0]  arb_grants;
    logic        ovr_en;
    logic [1:0]  ovr_val;

    arb_grant_mux #(.N(2), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .requests  (requests),
        .grants    (grants),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .count     (count),
        .err_grant (err_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin: arb_ptr names the channel with priority this cycle.
    always_comb begin
        arb_grants = 2'b00;
        if (!arb_ptr) begin
            if (requests[0])      arb_grants = 2'b01;
            else if (requests[1]) arb_grants = 2'b10;
        end else begin
            if (requests[1])      arb_grants = 2'b10;
            else if (requests[0]) arb_grants = 2'b01;
        end
    end

    // Pointer advances past the winner on any nonzero grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             arb_ptr <= 1'b0;
        else if (arb_grants[0]) arb_ptr <= 1'b1;
        else if (arb_grants[1]) arb_ptr <= 1'b0;
    end

    assign grants = ovr_en ? ovr_val : arb_grants;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 2'b00;
        in_data    = 16'h0000;
        out_ready  = 1'b0;
        ovr_en     = 1'b0;
        ovr_val    = 2'b00;

        // Reset state
        #3;
        in_valid = 2'b11;
        in_data  = 16'hB1A0;
        #1;
        check("rst_count",     16'(count),     16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data",  16'(out_data),  16'h00);
        check("rst_err",       16'(err_grant), 16'd0);
        check("rst_requests",  16'(requests),  16'b11);
        check("rst_in_ready",  16'(in_ready),  16'b01);
        $display("reset: count=%0d requests=%b in_ready=%b", count, requests, in_ready);

        // Alternating traffic, out_ready=1
        next_cycle;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("alt_c1_count",    16'(count),    16'd0);
        check("alt_c1_in_ready", 16'(in_ready), 16'b01);
        for (int c = 2; c <= 6; c++) begin
            next_cycle;
            #1;
            check("alt_valid", 16'(out_valid), 16'd1);
            check("alt_src",   16'(out_src),   (c % 2 == 0) ? 16'd0 : 16'd1);
            check("alt_data",  16'(out_data),  (c % 2 == 0) ? 16'hA0 : 16'hB1);
            check("alt_count", 16'(count),     16'd1);
            check("alt_err",   16'(err_grant), 16'd0);
            $display("alt cycle %0d: src=%0d data=%h count=%0d", c, out_src, out_data, count);
        end
        next_cycle;
        in_valid = 2'b00;
        #1;
        check("alt_c7_src",  16'(out_src),  16'd1);
        check("alt_c7_data", 16'(out_data), 16'hB1);

        // Single-channel beats one cycle apart
        next_cycle;
        in_valid = 2'b01;
        in_data  = 16'h0011;
        #1;
        check("seq_empty_valid", 16'(out_valid), 16'd0);
        check("seq_in_ready0",   16'(in_ready),  16'b01);
        next_cycle;
        in_valid = 2'b10;
        in_data  = 16'h2200;
        #1;
        check("seq_data0",     16'(out_data), 16'h11);
        check("seq_src0",      16'(out_src),  16'd0);
        check("seq_in_ready1", 16'(in_ready), 16'b10);
        next_cycle;
        in_valid = 2'b00;
        #1;
        check("seq_data1", 16'(out_data), 16'h22);
        check("seq_src1",  16'(out_src),  16'd1);
        check("seq_count", 16'(count),    16'd1);
        $display("seq: second beat data=%h src=%0d", out_data, out_src);

        // Backpressure
        next_cycle;
        in_valid  = 2'b11;
        in_data   = 16'hB1A0;
        out_ready = 1'b0;
        #1;
        check("bp_count0",    16'(count),    16'd0);
        check("bp_in_ready0", 16'(in_ready), 16'b01);
        next_cycle;
        #1;
        check("bp_count1",    16'(count),    16'd1);
        check("bp_in_ready1", 16'(in_ready), 16'b10);
        next_cycle;
        #1;
        check("bp_full_count",    16'(count),    16'd2);
        check("bp_full_requests", 16'(requests), 16'b00);
        check("bp_full_in_ready", 16'(in_ready), 16'b00);
        check("bp_full_src",      16'(out_src),  16'd0);
        check("bp_full_data",     16'(out_data), 16'hA0);
        next_cycle;
        out_ready = 1'b1;
        #1;
        check("bp_pop_src",      16'(out_src),  16'd0);
        check("bp_pop_requests", 16'(requests), 16'b00);
        next_cycle;
        out_ready = 1'b0;
        #1;
        check("bp_after_count",    16'(count),    16'd1);
        check("bp_after_requests", 16'(requests), 16'b11);
        check("bp_after_in_ready", 16'(in_ready), 16'b01);
        check("bp_after_src",      16'(out_src),  16'd1);
        $display("bp: after pop count=%0d requests=%b", count, requests);
        next_cycle;
        out_ready = 1'b1;
        in_valid  = 2'b00;
        #1;
        check("bp_refill_count", 16'(count), 16'd2);
        next_cycle;
        #1;
        check("drain_count", 16'(count),   16'd1);
        check("drain_src",   16'(out_src), 16'd0);

        // Illegal grant override
        next_cycle;
        in_valid = 2'b11;
        ovr_en   = 1'b1;
        ovr_val  = 2'b11;
        #1;
        check("ill_count",    16'(count),     16'd0);
        check("ill_in_ready", 16'(in_ready),  16'b00);
        check("ill_err_now",  16'(err_grant), 16'd0);
        next_cycle;
        ovr_en   = 1'b0;
        in_valid = 2'b00;
        #1;
        check("ill_err_next",  16'(err_grant), 16'd1);
        check("ill_no_push",   16'(count),     16'd0);
        check("ill_out_valid", 16'(out_valid), 16'd0);
        next_cycle;
        in_valid = 2'b01;
        #1;
        check("ill_legal_in_ready", 16'(in_ready), 16'b01);
        next_cycle;
        in_valid = 2'b00;
        #1;
        check("ill_legal_data", 16'(out_data),  16'hA0);
        check("ill_err_sticky", 16'(err_grant), 16'd1);
        $display("illegal: err_grant=%0d after legal beat", err_grant);

        // Fill, then asynchronous reset mid-cycle
        next_cycle;
        in_valid  = 2'b11;
        out_ready = 1'b0;
        #1;
        check("ar_count0",    16'(count),    16'd0);
        check("ar_in_ready0", 16'(in_ready), 16'b10);
        next_cycle;
        #1;
        check("ar_count1",    16'(count),    16'd1);
        check("ar_in_ready1", 16'(in_ready), 16'b01);
        next_cycle;
        #1;
        check("ar_full", 16'(count), 16'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_count",     16'(count),     16'd0);
        check("ar_out_valid", 16'(out_valid), 16'd0);
        check("ar_out_data",  16'(out_data),  16'h00);
        check("ar_out_src",   16'(out_src),   16'd0);
        check("ar_err",       16'(err_grant), 16'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("ar_release_requests", 16'(requests), 16'b11);
        in_valid = 2'b00;
        $display("async reset: count=%0d out_valid=%0d", count, out_valid);

        // Idle cycles then channel 1
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle;
            #1;
            check("idle_requests", 16'(requests), 16'b00);
            check("idle_in_ready", 16'(in_ready), 16'b00);
            check("idle_count",    16'(count),    16'd0);
        end
        next_cycle;
        in_valid = 2'b10;
        in_data  = 16'hC300;
        #1;
        check("idle_ch1_in_ready", 16'(in_ready), 16'b10);
        next_cycle;
        in_valid = 2'b00;
        #1;
        check("idle_ch1_valid", 16'(out_valid), 16'd1);
        check("idle_ch1_src",   16'(out_src),   16'd1);
        check("idle_ch1_data",  16'(out_data),  16'hC3);
        check("idle_ch1_count", 16'(count),     16'd1);
        $display("idle: first beat src=%0d data=%h", out_src, out_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
